// File: rtl/spi_sched_pkg.sv
// Shared types for the SPI transaction scheduler: FSM states, SPI field widths
// and word-length codes.
package spi_sched_pkg;

  localparam int MODE_W  = 2;
  localparam int SPEED_W = 2;
  localparam int LEN_W   = 2;
  localparam int DATA_W  = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_START,
    S_RUN,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [LEN_W-1:0] LEN_32 = 2'd0;
  localparam logic [LEN_W-1:0] LEN_16 = 2'd1;
  localparam logic [LEN_W-1:0] LEN_8  = 2'd2;
  localparam logic [LEN_W-1:0] LEN_4  = 2'd3;

  // Right-aligned mask of the bits a word-length code actually shifts.
  function automatic logic [DATA_W-1:0] len_mask(input logic [LEN_W-1:0] len);
    case (len)
      LEN_32:  len_mask = 32'hFFFF_FFFF;
      LEN_16:  len_mask = 32'h0000_FFFF;
      LEN_8:   len_mask = 32'h0000_00FF;
      default: len_mask = 32'h0000_000F;
    endcase
  endfunction

endpackage

// File: rtl/spi_txn_scheduler_if.sv
// Link between the scheduler and the SPI master: config, MOSI word, start/busy
// handshake and the returned MISO word.
interface spi_txn_scheduler_if;

  logic                               start;
  logic [spi_sched_pkg::MODE_W-1:0]   mode;
  logic [spi_sched_pkg::SPEED_W-1:0]  speed;
  logic [spi_sched_pkg::LEN_W-1:0]    len;
  logic [spi_sched_pkg::DATA_W-1:0]   mosi;
  logic                               busy;
  logic [spi_sched_pkg::DATA_W-1:0]   miso;

  modport master (output start, mode, speed, len, mosi, input busy, miso);
  modport slave  (input start, mode, speed, len, mosi, output busy, miso);

endinterface

// File: rtl/spi_txn_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i,
// searching cyclically, returned as one-hot grant plus index.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [IDX_W-1:0] cand;

  // NOTE: every output of a combinational block gets a default before any
  // branch; a path that leaves one unassigned would infer a latch.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = IDX_W'((int'(ptr_i) + i) % N_REQ);
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_txn_scheduler.sv
// Shares one SPI master among N_REQ requesters: round-robin grant, latched
// payload, start/busy sequencing with watchdogs, per-requester done/err pulse.
module spi_txn_scheduler
  import spi_sched_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int SETUP_CYC = 2,
  parameter int START_TO  = 1024,
  parameter int BUSY_TO   = 8192
) (
  input  logic                     GCLK,
  input  logic                     RST,
  input  logic [N_REQ-1:0]         req_i,
  input  logic [MODE_W*N_REQ-1:0]  req_mode_i,
  input  logic [SPEED_W*N_REQ-1:0] req_speed_i,
  input  logic [LEN_W*N_REQ-1:0]   req_len_i,
  input  logic [DATA_W*N_REQ-1:0]  req_data_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [N_REQ-1:0]         done_o,
  output logic [N_REQ-1:0]         err_o,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     sched_busy_o,
  spi_txn_scheduler_if.master      spi
);

  localparam int IDX_W  = $clog2(N_REQ);
  localparam int MAX_TO = (START_TO > BUSY_TO) ? START_TO : BUSY_TO;
  localparam int CNT_W  = $clog2(((MAX_TO > SETUP_CYC) ? MAX_TO : SETUP_CYC) + 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     g_q, g_d;
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [N_REQ-1:0]     gnt_q, gnt_d;
  logic [N_REQ-1:0]     done_q, done_d;
  logic [N_REQ-1:0]     err_q, err_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 start_q, start_d;
  logic [MODE_W-1:0]    mode_q, mode_d;
  logic [SPEED_W-1:0]   speed_q, speed_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [DATA_W-1:0]    mosi_q, mosi_d;

  logic [N_REQ-1:0]     arb_gnt;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_valid;
  logic [IDX_W-1:0]     rr_next;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
    .req_i   (req_i),
    .ptr_i   (rr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign rr_next = (g_q == IDX_W'(N_REQ - 1)) ? '0 : g_q + IDX_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    g_d     = g_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = '0;
    rdata_d = rdata_q;
    start_d = start_q;
    mode_d  = mode_q;
    speed_d = speed_q;
    len_d   = len_q;
    mosi_d  = mosi_q;
    case (state_q)
      S_IDLE: begin
        if (arb_valid) begin
          gnt_d   = arb_gnt;
          g_d     = arb_idx;
          mode_d  = MODE_W'(req_mode_i >> (MODE_W * arb_idx));
          speed_d = SPEED_W'(req_speed_i >> (SPEED_W * arb_idx));
          len_d   = LEN_W'(req_len_i >> (LEN_W * arb_idx));
          mosi_d  = DATA_W'(req_data_i >> (DATA_W * arb_idx));
          cnt_d   = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
          // Foreign activity on the master: hold start low until busy falls.
          start_d = !spi.busy;
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (start_q && spi.busy) begin
          start_d = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end else if (cnt_q == CNT_W'(START_TO - 1)) begin
          start_d = 1'b0;
          cnt_d   = '0;
          state_d = S_ERR;
        end else if (!spi.busy) begin
          start_d = 1'b1;
        end
      end
      S_RUN: begin
        if (!spi.busy) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else if (BUSY_TO != 0 && cnt_q == CNT_W'(BUSY_TO - 1)) begin
          cnt_d   = '0;
          state_d = S_ERR;
        end
      end
      S_DONE: begin
        rdata_d = spi.miso;
        done_d  = gnt_q;
        gnt_d   = '0;
        rr_d    = rr_next;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      S_ERR: begin
        err_d   = gnt_q;
        gnt_d   = '0;
        start_d = 1'b0;
        rr_d    = rr_next;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples the pre-edge value of every other flop, independent of order.
  always_ff @(posedge GCLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      g_q     <= '0;
      rr_q    <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      start_q <= 1'b0;
      mode_q  <= '0;
      speed_q <= '0;
      len_q   <= '0;
      mosi_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      g_q     <= g_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      start_q <= start_d;
      mode_q  <= mode_d;
      speed_q <= speed_d;
      len_q   <= len_d;
      mosi_q  <= mosi_d;
    end
  end

  assign gnt_o        = gnt_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign rdata_o      = rdata_q;
  assign sched_busy_o = (state_q != S_IDLE);
  assign spi.start    = start_q;
  assign spi.mode     = mode_q;
  assign spi.speed    = speed_q;
  assign spi.len      = len_q;
  assign spi.mosi     = mosi_q;

endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Scoreboard bench for spi_txn_scheduler against a behavioural SPI master that
// echoes the inverted, length-masked MOSI word.
module tb_spi_txn_scheduler;
  import spi_sched_pkg::*;

  localparam int N_REQ     = 4;
  localparam int SETUP_CYC = 2;
  localparam int START_TO  = 16;
  localparam int BUSY_TO   = 64;
  localparam int BUSY_LEN  = 6;

  logic                     GCLK = 1'b0;
  logic                     RST  = 1'b1;
  logic [N_REQ-1:0]         req_i = '0;
  logic [MODE_W*N_REQ-1:0]  req_mode_i;
  logic [SPEED_W*N_REQ-1:0] req_speed_i;
  logic [LEN_W*N_REQ-1:0]   req_len_i;
  logic [DATA_W*N_REQ-1:0]  req_data_i;
  logic [N_REQ-1:0]         gnt_o, done_o, err_o;
  logic [DATA_W-1:0]        rdata_o;
  logic                     sched_busy_o;

  always #5 GCLK = ~GCLK;

  spi_txn_scheduler_if spi_bus ();

  spi_txn_scheduler #(
    .N_REQ(N_REQ), .SETUP_CYC(SETUP_CYC), .START_TO(START_TO), .BUSY_TO(BUSY_TO)
  ) dut (
    .GCLK         (GCLK),
    .RST          (RST),
    .req_i        (req_i),
    .req_mode_i   (req_mode_i),
    .req_speed_i  (req_speed_i),
    .req_len_i    (req_len_i),
    .req_data_i   (req_data_i),
    .gnt_o        (gnt_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .rdata_o      (rdata_o),
    .sched_busy_o (sched_busy_o),
    .spi          (spi_bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          is_err;
    int          idx;
    logic [31:0] rdata;
    logic [31:0] mosi;
  } exp_t;

  exp_t sb[$];

  task automatic push(input bit is_err, input int idx, input logic [31:0] rdata,
                      input logic [31:0] mosi);
    exp_t e;
    e.is_err = is_err;
    e.idx    = idx;
    e.rdata  = rdata;
    e.mosi   = mosi;
    sb.push_back(e);
  endtask

  // Behavioural SPI master: busy for BUSY_LEN+1 cycles after a start rising edge.
  logic        m_dead = 1'b0, m_stuck = 1'b0;
  logic        m_busy = 1'b0, m_start_prev = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_echo = '0, m_miso = '0;
  int          start_rises = 0;

  assign spi_bus.busy = m_busy;
  assign spi_bus.miso = m_miso;

  always @(posedge GCLK) begin
    m_start_prev <= spi_bus.start;
    if (spi_bus.start && !m_start_prev) begin
      start_rises++;
      check("start_while_busy", 32'(m_busy), 32'd0);
    end
    if (m_busy) begin
      if (!m_stuck) begin
        if (m_cnt == 0) begin
          m_busy <= 1'b0;
          m_miso <= m_echo;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end else if (spi_bus.start && !m_start_prev && !m_dead) begin
      m_busy <= 1'b1;
      m_cnt  <= BUSY_LEN;
      m_echo <= ~spi_bus.mosi & len_mask(spi_bus.len);
    end
  end

  // Monitor: pops the scoreboard on every done/err pulse.
  always @(negedge GCLK) begin : monitor
    exp_t             e;
    logic [N_REQ-1:0] ev;
    int               idx;
    ev = done_o | err_o;
    if (gnt_o != '0) check("gnt_onehot", 32'($onehot(gnt_o)), 32'd1);
    if (ev != '0) begin
      idx = -1;
      for (int i = 0; i < N_REQ; i++) if (ev[i]) idx = i;
      check("one_pulse", 32'($onehot(ev)), 32'd1);
      check("gnt_dropped", 32'(gnt_o), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", {24'd0, done_o, err_o}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_kind_err", 32'(|err_o), 32'(e.is_err));
        check("pulse_index", idx, e.idx);
        check("rdata", rdata_o, e.rdata);
        check("mosi_held", spi_bus.mosi, e.mosi);
      end
    end
  end

  task automatic wait_gnt(input int idx);
    bit               found = 1'b0;
    logic [N_REQ-1:0] sh;
    for (int n = 0; n < 300 && !found; n++) begin
      @(negedge GCLK);
      sh    = gnt_o >> idx;
      found = sh[0];
    end
    check($sformatf("gnt%0d_seen", idx), 32'(found), 32'd1);
  endtask

  task automatic wait_done(input int idx);
    bit               found = 1'b0;
    logic [N_REQ-1:0] sh;
    for (int n = 0; n < 300 && !found; n++) begin
      @(negedge GCLK);
      sh    = done_o >> idx;
      found = sh[0];
    end
    check($sformatf("done%0d_seen", idx), 32'(found), 32'd1);
  endtask

  task automatic wait_start();
    bit found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge GCLK);
      found = spi_bus.start;
    end
    check("start_seen", 32'(found), 32'd1);
  endtask

  task automatic cycles_to_err(output int n);
    n = 0;
    while (err_o == '0 && n < 200) begin
      @(negedge GCLK);
      n++;
    end
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge GCLK);
      ok = (sb.size() == 0) && !sched_busy_o && !m_busy;
    end
    check("drain", 32'(ok), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},   32'(gnt_o), 32'd0);
    check({tag, "_done"},  32'(done_o), 32'd0);
    check({tag, "_err"},   32'(err_o), 32'd0);
    check({tag, "_rdata"}, rdata_o, 32'd0);
    check({tag, "_busy"},  32'(sched_busy_o), 32'd0);
    check({tag, "_start"}, 32'(spi_bus.start), 32'd0);
    check({tag, "_cfg"},   {26'd0, spi_bus.mode, spi_bus.speed, spi_bus.len}, 32'd0);
    check({tag, "_mosi"},  spi_bus.mosi, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    // Requester i: mode=i, speed=~i, len codes {3,1,2,0}, fixed MOSI words.
    req_mode_i  = {2'b11, 2'b10, 2'b01, 2'b00};
    req_speed_i = {2'b00, 2'b01, 2'b10, 2'b11};
    req_len_i   = {LEN_4, LEN_16, LEN_8, LEN_32};
    req_data_i  = {32'hFFFF_FFF5, 32'h0000_BEEF, 32'hA5A5_00C3, 32'h1234_5678};

    repeat (3) @(negedge GCLK);
    check_all_zero("reset");
    RST = 1'b0;
    @(negedge GCLK);
    check("idle_after_reset", 32'(sched_busy_o), 32'd0);

    // Contention from rr_ptr=0: 0,1,2,3,0.
    push(1'b0, 0, 32'hEDCB_A987, 32'h1234_5678);
    push(1'b0, 1, 32'h0000_003C, 32'hA5A5_00C3);
    push(1'b0, 2, 32'h0000_4110, 32'h0000_BEEF);
    push(1'b0, 3, 32'h0000_000A, 32'hFFFF_FFF5);
    push(1'b0, 0, 32'hEDCB_A987, 32'h1234_5678);
    req_i = 4'b1111;
    wait_gnt(0);
    wait_gnt(1);
    wait_gnt(2);
    wait_gnt(3);
    wait_gnt(0);
    req_i = 4'b0000;
    drain();

    // Single transaction on requester 1, 8-bit word.
    start_rises = 0;
    push(1'b0, 1, 32'h0000_003C, 32'hA5A5_00C3);
    req_i = 4'b0010;
    wait_gnt(1);
    req_i = 4'b0000;
    check("single_mode",  32'(spi_bus.mode), 32'h1);
    check("single_speed", 32'(spi_bus.speed), 32'h2);
    check("single_len",   32'(spi_bus.len), 32'h2);
    check("single_mosi",  spi_bus.mosi, 32'hA5A5_00C3);
    n = 0;
    while (!spi_bus.start && n < 20) begin
      @(negedge GCLK);
      n++;
    end
    check("setup_latency", n, SETUP_CYC);
    drain();
    check("single_start_rises", start_rises, 1);

    // Fairness: req0 re-asserts right after its done while req2 waits.
    push(1'b0, 0, 32'hEDCB_A987, 32'h1234_5678);
    push(1'b0, 2, 32'h0000_4110, 32'h0000_BEEF);
    push(1'b0, 0, 32'hEDCB_A987, 32'h1234_5678);
    req_i = 4'b0001;
    wait_gnt(0);
    req_i = 4'b0100;
    wait_done(0);
    req_i = 4'b0101;
    wait_gnt(2);
    req_i = 4'b0001;
    wait_gnt(0);
    req_i = 4'b0000;
    drain();

    // Start timeout: master never answers.
    m_dead = 1'b1;
    push(1'b1, 3, 32'hEDCB_A987, 32'hFFFF_FFF5);
    req_i = 4'b1000;
    wait_gnt(3);
    req_i = 4'b0000;
    wait_start();
    cycles_to_err(n);
    check("start_timeout_cycles", n, START_TO + 1);
    drain();
    m_dead = 1'b0;
    push(1'b0, 1, 32'h0000_003C, 32'hA5A5_00C3);
    req_i = 4'b0010;
    wait_gnt(1);
    req_i = 4'b0000;
    drain();

    // Busy timeout: busy stuck high; rdata keeps the previous word.
    m_stuck = 1'b1;
    push(1'b1, 2, 32'h0000_003C, 32'h0000_BEEF);
    req_i = 4'b0100;
    wait_gnt(2);
    req_i = 4'b0000;
    wait_start();
    cycles_to_err(n);
    check("busy_timeout_cycles", n, 2 + BUSY_TO + 1);
    m_stuck = 1'b0;
    drain();

    // Reset in RUN, then a request that finds the master still busy.
    req_i = 4'b1000;
    wait_gnt(3);
    req_i = 4'b0000;
    n = 0;
    while (!spi_bus.busy && n < 50) begin
      @(negedge GCLK);
      n++;
    end
    check("run_busy_seen", 32'(spi_bus.busy), 32'd1);
    @(negedge GCLK);
    RST = 1'b1;
    @(negedge GCLK);
    RST = 1'b0;
    check_all_zero("midrun_reset");
    push(1'b0, 0, 32'hEDCB_A987, 32'h1234_5678);
    req_i = 4'b0001;
    wait_gnt(0);
    req_i = 4'b0000;
    drain();

    repeat (5) @(negedge GCLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
